// File: rtl/key_press_classifier.sv
// ============================================================================
// key_press_classifier
// Sorts each completed single-key press into short or long, reports the key
// index, and flags presses where a second key appears.
// Optional feature macro: KPC_REPEAT_EN enables auto-repeat ticks on long holds.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_press_classifier #(
  parameter int NUM_KEYS      = 12,
  parameter int LONG_CYCLES   = 30,
  parameter int REPEAT_CYCLES = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         key_in,
  output logic                        short_valid,
  output logic                        long_valid,
  output logic                        repeat_valid,
  output logic [$clog2(NUM_KEYS)-1:0] key_code,
  output logic                        multi_err,
  output logic                        busy
);

  localparam int KEY_W = $clog2(NUM_KEYS);
  localparam int CNT_W = $clog2(LONG_CYCLES + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HELD     = 2'd1;
  localparam logic [1:0] S_WAIT_REL = 2'd2;

  localparam logic [CNT_W-1:0] C_LONG = CNT_W'(LONG_CYCLES);

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_next;
  logic [CNT_W-1:0]    w_count_inc;
  logic [KEY_W-1:0]    r_own;
  logic [KEY_W-1:0]    w_own_next;
  logic [KEY_W-1:0]    w_code_next;
  logic [KEY_W-1:0]    w_idx;
  logic                w_short_next;
  logic                w_long_next;
  logic                w_multi_next;
  logic                w_any;
  logic                w_onehot;
  logic                w_owner;
  logic                w_others;
  logic [NUM_KEYS-1:0] w_own_mask;

  assign w_any      = |key_in;
  assign w_onehot   = w_any && ((key_in & (key_in - NUM_KEYS'(1))) == '0);
  assign w_own_mask = NUM_KEYS'(1) << r_own;
  assign w_owner    = |(key_in & w_own_mask);
  assign w_others   = |(key_in & ~w_own_mask);
  assign w_count_inc = (r_count == C_LONG) ? C_LONG : r_count + CNT_W'(1);
  assign busy       = (r_state != S_IDLE);

  always_comb begin
    w_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_in[i]) w_idx = KEY_W'(i);
    end
  end

`ifdef KPC_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] C_REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic [REP_W-1:0] w_rep_cnt_next;
  logic             w_rep_next;
`else
  assign repeat_valid = 1'b0;
`endif

  // State register plus all registered outputs; reset parks in WAIT_REL so a
  // key held through reset is never reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_WAIT_REL;
      r_count     <= '0;
      r_own       <= '0;
      short_valid <= 1'b0;
      long_valid  <= 1'b0;
      multi_err   <= 1'b0;
      key_code    <= '0;
`ifdef KPC_REPEAT_EN
      r_rep_cnt    <= '0;
      repeat_valid <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_own       <= w_own_next;
      short_valid <= w_short_next;
      long_valid  <= w_long_next;
      multi_err   <= w_multi_next;
      key_code    <= w_code_next;
`ifdef KPC_REPEAT_EN
      r_rep_cnt    <= w_rep_cnt_next;
      repeat_valid <= w_rep_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_onehot)   w_state_next = S_HELD;
        else if (w_any) w_state_next = S_WAIT_REL;
      end
      S_HELD: begin
        if (w_others)      w_state_next = S_WAIT_REL;
        else if (!w_owner) w_state_next = S_IDLE;
      end
      S_WAIT_REL: begin
        if (!w_any) w_state_next = S_IDLE;
      end
      default: w_state_next = S_WAIT_REL;
    endcase
  end

  always_comb begin
    w_short_next = 1'b0;
    w_long_next  = 1'b0;
    w_multi_next = 1'b0;
    w_code_next  = key_code;
    w_count_next = r_count;
    w_own_next   = r_own;
`ifdef KPC_REPEAT_EN
    w_rep_next     = 1'b0;
    w_rep_cnt_next = r_rep_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_own_next   = w_idx;
          w_count_next = CNT_W'(1);
`ifdef KPC_REPEAT_EN
          w_rep_cnt_next = '0;
`endif
        end else if (w_any) begin
          w_multi_next = 1'b1;
        end
      end
      S_HELD: begin
        if (w_others) begin
          w_multi_next = 1'b1;
        end else if (w_owner) begin
          w_count_next = w_count_inc;
`ifdef KPC_REPEAT_EN
          // First tick on the edge the count saturates, then one per period.
          if (r_count != C_LONG && w_count_inc == C_LONG) begin
            w_rep_next     = 1'b1;
            w_rep_cnt_next = '0;
            w_code_next    = r_own;
          end else if (r_count == C_LONG) begin
            if (r_rep_cnt == C_REP_LAST) begin
              w_rep_next     = 1'b1;
              w_rep_cnt_next = '0;
              w_code_next    = r_own;
            end else begin
              w_rep_cnt_next = r_rep_cnt + REP_W'(1);
            end
          end
`endif
        end else begin
          w_code_next = r_own;
          if (r_count < C_LONG) w_short_next = 1'b1;
          else                  w_long_next  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_key_press_classifier.sv
// Directed bench for key_press_classifier at default parameters.
`timescale 1ns/1ps
`default_nettype none

module tb_key_press_classifier;

  localparam int NUM_KEYS = 12;
  localparam int KEY_W    = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_KEYS-1:0] key_in = '0;
  logic                short_valid, long_valid, repeat_valid, multi_err, busy;
  logic [KEY_W-1:0]    key_code;

  int n_total = 0;
  int n_pass  = 0;

  key_press_classifier dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .short_valid  (short_valid),
    .long_valid   (long_valid),
    .repeat_valid (repeat_valid),
    .key_code     (key_code),
    .multi_err    (multi_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold one key for n sampling edges, then release and advance to the pulse.
  task automatic press(input int key, input int n);
    key_in = '0;
    key_in[key] = 1'b1;
    repeat (n) step();
    key_in = '0;
    step();
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if ({short_valid, long_valid, repeat_valid, multi_err, busy, key_code} !== {5'b00001, 4'd0})
      $display("FAIL reset_state: got sv=%b lv=%b rv=%b me=%b busy=%b code=%0d, want 0 0 0 0 1 0",
               short_valid, long_valid, repeat_valid, multi_err, busy, key_code);
    else n_pass++;
    #10 rst_n = 1'b1;
    step();
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_short();
    int early;
    early = 0;
    key_in = '0;
    key_in[10] = 1'b1;
    repeat (5) begin
      step();
      if (short_valid || long_valid) early++;
    end
    key_in = '0;
    step();
    n_total++;
    if (early !== 0) $display("FAIL short_hold_quiet: %0d early pulses, want 0", early);
    else n_pass++;
    n_total++;
    if ({short_valid, long_valid, key_code} !== {2'b10, 4'd10})
      $display("FAIL short_k10: sv=%b lv=%b code=%0d want 1 0 10", short_valid, long_valid, key_code);
    else n_pass++;
    step();
    n_total++;
    if ({short_valid, key_code} !== {1'b0, 4'd10})
      $display("FAIL short_k10_after: sv=%b code=%0d want 0 10", short_valid, key_code);
    else n_pass++;
  endtask

  task automatic test_boundary();
    press(11, 29);
    n_total++;
    if ({short_valid, long_valid, key_code} !== {2'b10, 4'd11})
      $display("FAIL hold29_short: sv=%b lv=%b code=%0d want 1 0 11", short_valid, long_valid, key_code);
    else n_pass++;
    press(11, 30);
    n_total++;
    if ({short_valid, long_valid, key_code} !== {2'b01, 4'd11})
      $display("FAIL hold30_long: sv=%b lv=%b code=%0d want 0 1 11", short_valid, long_valid, key_code);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    press(2, 1);
    n_total++;
    if ({short_valid, key_code} !== {1'b1, 4'd2})
      $display("FAIL b2b_first: sv=%b code=%0d want 1 2", short_valid, key_code);
    else n_pass++;
    press(6, 2);
    n_total++;
    if ({short_valid, key_code} !== {1'b1, 4'd6})
      $display("FAIL b2b_second: sv=%b code=%0d want 1 6", short_valid, key_code);
    else n_pass++;
  endtask

  task automatic test_multi_late();
    int stray;
    stray = 0;
    key_in = '0;
    key_in[3] = 1'b1;
    repeat (3) step();
    key_in[7] = 1'b1;
    step();
    n_total++;
    if ({multi_err, busy, short_valid, long_valid} !== 4'b1100)
      $display("FAIL multi_late_err: me=%b busy=%b sv=%b lv=%b want 1 1 0 0",
               multi_err, busy, short_valid, long_valid);
    else n_pass++;
    step();
    if (short_valid || long_valid || multi_err) stray++;
    key_in[3] = 1'b0;
    repeat (2) begin
      step();
      if (short_valid || long_valid || multi_err) stray++;
    end
    n_total++;
    if (busy !== 1'b1) $display("FAIL multi_late_busy: busy=%b want 1", busy);
    else n_pass++;
    key_in = '0;
    step();
    if (short_valid || long_valid || multi_err) stray++;
    n_total++;
    if (stray !== 0 || busy !== 1'b0)
      $display("FAIL multi_late_quiet: stray=%0d busy=%b want 0 0", stray, busy);
    else n_pass++;
    press(7, 3);
    n_total++;
    if ({short_valid, long_valid, key_code} !== {2'b10, 4'd7})
      $display("FAIL multi_late_k7: sv=%b lv=%b code=%0d want 1 0 7", short_valid, long_valid, key_code);
    else n_pass++;
  endtask

  task automatic test_multi_same_edge();
    key_in = '0;
    key_in[1] = 1'b1;
    key_in[2] = 1'b1;
    step();
    n_total++;
    if ({multi_err, busy} !== 2'b11)
      $display("FAIL same_edge_err: me=%b busy=%b want 1 1", multi_err, busy);
    else n_pass++;
    step();
    key_in[1] = 1'b0;
    step();
    n_total++;
    if ({multi_err, busy, short_valid} !== 3'b010)
      $display("FAIL same_edge_hold: me=%b busy=%b sv=%b want 0 1 0", multi_err, busy, short_valid);
    else n_pass++;
    key_in = '0;
    step();
    n_total++;
    if ({busy, short_valid, long_valid} !== 3'b000)
      $display("FAIL same_edge_rel: busy=%b sv=%b lv=%b want 0 0 0", busy, short_valid, long_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_press();
    int stray;
    stray = 0;
    key_in = '0;
    key_in[5] = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    #2;
    n_total++;
    if ({busy, short_valid, long_valid, key_code} !== {3'b100, 4'd0})
      $display("FAIL midreset_clear: busy=%b sv=%b lv=%b code=%0d want 1 0 0 0",
               busy, short_valid, long_valid, key_code);
    else n_pass++;
    rst_n = 1'b1;
    repeat (5) begin
      step();
      if (short_valid || long_valid || multi_err || !busy) stray++;
    end
    key_in = '0;
    step();
    if (short_valid || long_valid || multi_err) stray++;
    n_total++;
    if (stray !== 0 || busy !== 1'b0)
      $display("FAIL midreset_quiet: stray=%0d busy=%b want 0 0", stray, busy);
    else n_pass++;
    press(5, 2);
    n_total++;
    if ({short_valid, key_code} !== {1'b1, 4'd5})
      $display("FAIL midreset_new: sv=%b code=%0d want 1 5", short_valid, key_code);
    else n_pass++;
  endtask

`ifdef KPC_REPEAT_EN
  task automatic test_repeat();
    int bad;
    bit exp;
    bad = 0;
    key_in = '0;
    key_in[4] = 1'b1;
    for (int i = 1; i <= 55; i++) begin
      step();
      exp = (i == 30 || i == 40 || i == 50);
      n_total++;
      if (repeat_valid !== exp || (exp && key_code !== 4'd4)) begin
        $display("FAIL repeat_tick_%0d: rv=%b code=%0d want %b 4", i, repeat_valid, key_code, exp);
        bad++;
      end else n_pass++;
    end
    key_in = '0;
    step();
    n_total++;
    if ({long_valid, repeat_valid, key_code} !== {2'b10, 4'd4})
      $display("FAIL repeat_release: lv=%b rv=%b code=%0d want 1 0 4", long_valid, repeat_valid, key_code);
    else n_pass++;
  endtask
`else
  task automatic test_no_repeat();
    int seen;
    seen = 0;
    key_in = '0;
    key_in[4] = 1'b1;
    repeat (45) begin
      step();
      if (repeat_valid !== 1'b0) seen++;
    end
    key_in = '0;
    step();
    n_total++;
    if (seen !== 0 || long_valid !== 1'b1)
      $display("FAIL no_repeat: repeat pulses=%0d lv=%b want 0 1", seen, long_valid);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_short();
    test_boundary();
    test_back_to_back();
    test_multi_late();
    test_multi_same_edge();
    test_reset_mid_press();
`ifdef KPC_REPEAT_EN
    test_repeat();
`else
    test_no_repeat();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
